// File: rtl/icache_refill_ctrl_pkg.sv
// Shared fetch-side refill types, line geometry and the line-base helper.
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
package cpu_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} refill_state_t;

  localparam int DFLT_LINE_WORDS = 4;
  localparam int LINE_OFF_W      = $clog2(DFLT_LINE_WORDS) + 2;
  localparam int PA_W            = `PHYSICAL_ADDR_WIDTH;

  // Clears the in-line byte offset so the result points at word 0 of the line.
  function automatic logic [PA_W-1:0] line_base(input logic [PA_W-1:0] addr, input int off_w);
    return (addr >> off_w) << off_w;
  endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Memory burst port of the refill controller: one request/grant, then rvalid beats.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata, mem_err);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata, mem_err);
endinterface

// File: rtl/icache_refill_ctrl_beat_counter.sv
// Wrapping word index for a line burst plus a last-beat flag; shared with the D-cache.
// Outputs are registered; load takes priority over step.
module icache_beat_counter #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic             last
);
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // idx wraps for free because LINE_WORDS is a power of two; cnt tracks beats taken.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load) begin
      idx_d = start_idx;
      cnt_d = '0;
    end else if (step) begin
      idx_d = idx_q + IDX_W'(1);
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == IDX_W'(LINE_WORDS - 1));
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: stalls fetch, bursts one line, writes it, then releases.
// ICACHE_CRITICAL_WORD_FIRST_EN starts the burst at the missing word and forwards it.
module icache_refill_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int LINE_WORDS = cpu_fetch_pkg::DFLT_LINE_WORDS,
  parameter int ADDR_W     = `PHYSICAL_ADDR_WIDTH,
  parameter int DATA_W     = `INSTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  input  logic [ADDR_W-1:0]    pc,
  input  logic                 tlb_hit,
  input  logic                 cache_hit,
  input  logic                 jump,
  input  logic                 exception,
  output logic                 stall,
  icache_refill_ctrl_if.master mem,
  output logic                 fill_we,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 fill_line_vld,
  output logic                 bus_fault,
  output logic                 fwd_valid,
  output logic [DATA_W-1:0]    fwd_instr
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;

  refill_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              squash_q, squash_d;
  logic              err_q, err_d;
  logic              fill_line_vld_q, fill_line_vld_d;
  logic              bus_fault_q, bus_fault_d;
  logic              miss, redirect, beat, cnt_load, last;
  logic [IDX_W-1:0]  idx, start_idx;

  assign miss     = fetch_valid & tlb_hit & ~cache_hit & ~jump & ~exception;
  assign redirect = jump | exception;
  assign beat     = (state_q == FILL) & mem.mem_rvalid;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] crit_q, crit_d;
  logic             first_q, first_d;
  assign start_idx = crit_q;
`else
  assign start_idx = '0;
`endif

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    mem_addr_d      = mem_addr_q;
    mem_req_d       = mem_req_q;
    squash_d        = squash_q;
    err_d           = err_q;
    fill_line_vld_d = 1'b0;
    bus_fault_d     = 1'b0;
    cnt_load        = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    crit_d          = crit_q;
    first_d         = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d    = REQ;
          base_d     = ADDR_W'(line_base(PA_W'(pc), OFF_W));
          mem_req_d  = 1'b1;
          squash_d   = 1'b0;
          err_d      = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          crit_d     = pc[OFF_W-1:2];
          mem_addr_d = base_d | ADDR_W'({crit_d, 2'b00});
`else
          mem_addr_d = base_d;
`endif
        end
      end
      REQ: begin
        // A grant commits the burst even if a redirect lands in the same cycle.
        if (mem.mem_gnt) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          squash_d  = redirect;
          cnt_load  = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          first_d   = 1'b1;
`endif
        end else if (redirect) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      FILL: begin
        if (redirect) squash_d = 1'b1;
        if (beat) begin
          if (mem.mem_err) err_d = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          first_d = 1'b0;
`endif
          if (last) begin
            state_d         = DONE;
            fill_line_vld_d = ~err_d & ~squash_d;
            bus_fault_d     = err_d & ~squash_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      mem_addr_q      <= '0;
      mem_req_q       <= 1'b0;
      squash_q        <= 1'b0;
      err_q           <= 1'b0;
      fill_line_vld_q <= 1'b0;
      bus_fault_q     <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      crit_q          <= '0;
      first_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      mem_addr_q      <= mem_addr_d;
      mem_req_q       <= mem_req_d;
      squash_q        <= squash_d;
      err_q           <= err_d;
      fill_line_vld_q <= fill_line_vld_d;
      bus_fault_q     <= bus_fault_d;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      crit_q          <= crit_d;
      first_q         <= first_d;
`endif
    end
  end

  icache_beat_counter #(.LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .start_idx (start_idx),
    .step      (beat),
    .idx       (idx),
    .last      (last)
  );

  assign stall         = (state_q == IDLE) ? miss : 1'b1;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = mem_addr_q;
  assign fill_we       = beat;
  assign fill_addr     = beat ? (base_q | ADDR_W'({idx, 2'b00})) : '0;
  assign fill_data     = beat ? mem.mem_rdata : '0;
  assign fill_line_vld = fill_line_vld_q;
  assign bus_fault     = bus_fault_q;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign fwd_valid = beat & first_q & ~squash_q & ~mem.mem_err;
  assign fwd_instr = fwd_valid ? mem.mem_rdata : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_instr = '0;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a transaction-level reference model.
module tb_icache_refill_ctrl;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          tlb_hit = 1'b0;
  logic          cache_hit = 1'b0;
  logic          jump = 1'b0;
  logic          exception = 1'b0;
  logic          stall, fill_we, fill_line_vld, bus_fault, fwd_valid;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data, fwd_instr;

  icache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .pc(pc), .tlb_hit(tlb_hit),
    .cache_hit(cache_hit), .jump(jump), .exception(exception), .stall(stall), .mem(mem),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_line_vld(fill_line_vld), .bus_fault(bus_fault), .fwd_valid(fwd_valid),
    .fwd_instr(fwd_instr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  // Reference model: refill transaction as a line request followed by LW beats.
  bit          m_busy, m_req, m_fill, m_sq, m_er, m_lv, m_bf;
  int          m_got, m_start;
  logic [31:0] m_base, m_addr;

  // DUT activity logs checked against hand-computed literals per scenario.
  logic [31:0] fa_q[$];
  int          n_lv, n_bf, n_req, n_fwd;
  logic [31:0] req_addr;

  task automatic clear_logs();
    fa_q.delete();
    n_lv = 0; n_bf = 0; n_req = 0; n_fwd = 0; req_addr = '0;
  endtask

  initial begin
    logic        miss, e_we, e_fwd;
    logic [31:0] e_fa, e_fd, e_fi;
    int          crit;
    m_busy = 0; m_req = 0; m_fill = 0; m_sq = 0; m_er = 0; m_lv = 0; m_bf = 0;
    m_got = 0; m_start = 0; m_base = '0; m_addr = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      miss  = fetch_valid && tlb_hit && !cache_hit && !jump && !exception;
      e_we  = m_fill && mem.mem_rvalid;
      e_fa  = e_we ? m_base + 32'(((m_start + m_got) % LW) * 4) : 32'h0;
      e_fd  = e_we ? mem.mem_rdata : 32'h0;
      e_fwd = CWF && e_we && (m_got == 0) && !m_sq && !mem.mem_err;
      e_fi  = e_fwd ? mem.mem_rdata : 32'h0;
      chk("stall", stall, m_busy || miss);
      chk("mem_req", mem.mem_req, m_req);
      chk("mem_addr", mem.mem_addr, m_addr);
      chk("fill_we", fill_we, e_we);
      chk("fill_addr", fill_addr, e_fa);
      chk("fill_data", fill_data, e_fd);
      chk("fill_line_vld", fill_line_vld, m_lv);
      chk("bus_fault", bus_fault, m_bf);
      chk("fwd_valid", fwd_valid, e_fwd);
      chk("fwd_instr", fwd_instr, e_fi);
      if (fill_we) fa_q.push_back(fill_addr);
      if (fill_line_vld) n_lv++;
      if (bus_fault) n_bf++;
      if (fwd_valid) n_fwd++;
      if (mem.mem_req) begin n_req++; req_addr = mem.mem_addr; end
      // advance to the next cycle
      if (!rst_n) begin
        m_busy = 0; m_req = 0; m_fill = 0; m_sq = 0; m_er = 0; m_lv = 0; m_bf = 0;
        m_got = 0; m_addr = '0; m_base = '0;
      end else begin
        m_lv = 0; m_bf = 0;
        if (!m_busy) begin
          if (miss) begin
            m_busy  = 1; m_req = 1; m_sq = 0; m_er = 0;
            m_base  = pc & ~32'(LW * 4 - 1);
            crit    = int'((pc >> 2) % LW);
            m_start = CWF ? crit : 0;
            m_addr  = m_base + 32'(m_start * 4);
          end
        end else if (m_req) begin
          if (mem.mem_gnt) begin
            m_req = 0; m_fill = 1; m_got = 0; m_sq = jump || exception;
          end else if (jump || exception) begin
            m_req = 0; m_busy = 0;
          end
        end else if (m_fill) begin
          if (jump || exception) m_sq = 1;
          if (mem.mem_rvalid) begin
            if (mem.mem_err) m_er = 1;
            m_got++;
            if (m_got == LW) begin
              m_fill = 0;
              m_lv = !m_er && !m_sq;
              m_bf = m_er && !m_sq;
            end
          end
        end else begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_miss(input logic [31:0] a, input int gnt_wait, input bit jump_req,
                          input bit jump_gnt, input int jump_beat, input int err_beat);
    clear_logs();
    fetch_valid = 1; tlb_hit = 1; cache_hit = 0; pc = a;
    step();
    fetch_valid = 0; cache_hit = 1;
    if (jump_req) begin
      jump = 1; step(); jump = 0;
      repeat (2) step();
      return;
    end
    for (int i = 0; i < gnt_wait; i++) begin
      mem.mem_rvalid = (i == 0);
      mem.mem_rdata  = 32'hDEAD_0000;
      step();
      mem.mem_rvalid = 0;
    end
    mem.mem_gnt = 1; jump = jump_gnt; step();
    mem.mem_gnt = 0; jump = 0;
    for (int b = 0; b < LW; b++) begin
      if (b == 2) step();
      mem.mem_rvalid = 1; mem.mem_rdata = 32'hC0DE_0000 + 32'(b);
      mem.mem_err = (b == err_beat); jump = (b == jump_beat);
      step();
      mem.mem_rvalid = 0; mem.mem_err = 0; jump = 0;
    end
    repeat (3) step();
  endtask

  initial begin
    mem.mem_gnt = 0; mem.mem_rvalid = 0; mem.mem_rdata = '0; mem.mem_err = 0;
    repeat (3) step();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem.mem_req, 0);
    chk("rst_mem_addr", mem.mem_addr, 0);
    chk("rst_fill_line_vld", fill_line_vld, 0);
    rst_n = 1;
    step();

    // hit path
    clear_logs();
    fetch_valid = 1; tlb_hit = 1; cache_hit = 1; pc = 32'h200;
    #1 chk("hit_stall", stall, 0);
    repeat (3) step();
    chk("hit_no_req", n_req, 0);

    // plain miss at 0x104
    run_miss(32'h104, 2, 0, 0, -1, -1);
    chk("miss_req_cycles", n_req, 3);
    chk("miss_mem_addr", req_addr, CWF ? 32'h104 : 32'h100);
    chk("miss_nbeats", fa_q.size(), 4);
    if (fa_q.size() == 4) begin
      chk("miss_fa0", fa_q[0], CWF ? 32'h104 : 32'h100);
      chk("miss_fa1", fa_q[1], CWF ? 32'h108 : 32'h104);
      chk("miss_fa2", fa_q[2], CWF ? 32'h10C : 32'h108);
      chk("miss_fa3", fa_q[3], CWF ? 32'h100 : 32'h10C);
    end
    chk("miss_lv_pulses", n_lv, 1);
    chk("miss_bf_pulses", n_bf, 0);
    chk("miss_fwd_pulses", n_fwd, CWF ? 1 : 0);

    // jump before grant
    run_miss(32'h340, 0, 1, 0, -1, -1);
    chk("jreq_req_cycles", n_req, 1);
    chk("jreq_no_fill", fa_q.size(), 0);
    chk("jreq_idle_stall", stall, 0);
    chk("jreq_mem_req", mem.mem_req, 0);

    // jump on beat 2: beats still written, line not validated
    run_miss(32'h408, 1, 0, 0, 1, -1);
    chk("jbeat_nbeats", fa_q.size(), 4);
    chk("jbeat_lv", n_lv, 0);
    chk("jbeat_bf", n_bf, 0);

    // jump together with grant
    run_miss(32'h50C, 0, 0, 1, -1, -1);
    chk("jgnt_nbeats", fa_q.size(), 4);
    chk("jgnt_lv", n_lv, 0);

    // error on beat 3
    run_miss(32'h600, 1, 0, 0, -1, 2);
    chk("err_lv", n_lv, 0);
    chk("err_bf", n_bf, 1);

    // TLB miss never refills
    clear_logs();
    fetch_valid = 1; tlb_hit = 0; cache_hit = 0; pc = 32'h700;
    repeat (4) step();
    chk("tlbmiss_no_req", n_req, 0);
    chk("tlbmiss_stall", stall, 0);
    fetch_valid = 0;

    // reset in the middle of a fill
    fetch_valid = 1; tlb_hit = 1; cache_hit = 0; pc = 32'h80;
    step();
    fetch_valid = 0; cache_hit = 1;
    mem.mem_gnt = 1; step(); mem.mem_gnt = 0;
    for (int b = 0; b < 2; b++) begin
      mem.mem_rvalid = 1; mem.mem_rdata = 32'h1111_0000 + 32'(b); step();
      mem.mem_rvalid = 0;
    end
    rst_n = 0;
    step();
    #1;
    chk("rstfill_stall", stall, 0);
    chk("rstfill_mem_req", mem.mem_req, 0);
    chk("rstfill_fill_we", fill_we, 0);
    chk("rstfill_lv", fill_line_vld, 0);
    chk("rstfill_fill_addr", fill_addr, 0);
    rst_n = 1;
    clear_logs();
    mem.mem_rvalid = 1; step(); mem.mem_rvalid = 0;
    step();
    chk("idle_rvalid_ignored", fa_q.size(), 0);
    run_miss(32'h80, 0, 0, 0, -1, -1);
    chk("after_rst_lv", n_lv, 1);
    chk("after_rst_nbeats", fa_q.size(), 4);
    if (fa_q.size() == 4) chk("after_rst_fa0", fa_q[0], 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
